freq_sel_ctrl: RTL and testbench

FREQ_SEL_CTRL -- requirements
Module: freq_sel_ctrl

---
 rtl/freq_sel_pkg.sv | 15 +
 rtl/freq_sel_ctrl_if.sv | 25 ++
 rtl/freq_sel_ctrl_btn_debounce.sv | 54 +++++
 rtl/freq_sel_ctrl.sv | 107 ++++++++++
 tb/tb_freq_sel_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/freq_sel_pkg.sv
// Shared types and constants for the clock-mode selector.
package freq_sel_pkg;

    localparam int MODE_W = 3;
    localparam logic [MODE_W-1:0] MODE_MIN = 3'd0;
    localparam logic [MODE_W-1:0] MODE_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        ERR      = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/freq_sel_ctrl_if.sv
// Handshake between the mode selector and the downstream clock manager,
// plus the selector's status flags.
interface freq_sel_ctrl_if;
    import freq_sel_pkg::*;

    logic [MODE_W-1:0] prog_in;   // requested mode index
    logic              update;    // one-cycle load strobe
    logic [MODE_W-1:0] prog_out;  // mode the clock manager is generating
    logic              busy;
    logic              err;
    logic              limit;

    // Selector side
    modport master (
        output prog_in, update, busy, err, limit,
        input  prog_out
    );

    // Clock manager / observer side
    modport slave (
        input  prog_in, update, busy, err, limit,
        output prog_out
    );

endinterface

// File: rtl/freq_sel_ctrl_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability debounce and
// rising-edge (press) detection on the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CNT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

    logic             sync_p0;
    logic             sync_p1;
    logic             stable;
    logic             stable_dly;
    logic [CNT_W-1:0] cnt;

    // Two-stage synchronizer for the raw asynchronous button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // Accept a new level only after it has disagreed with the stable level
    // for DEBOUNCE_CNT consecutive cycles; any agreement restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable     <= 1'b0;
            stable_dly <= 1'b0;
            cnt        <= '0;
        end else begin
            stable_dly <= stable;
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
                stable <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Both operands are registers, so the press pulse is glitch-free
    assign press = stable & ~stable_dly;

endmodule

// File: rtl/freq_sel_ctrl.sv
// Button-driven clock-mode selector: debounced up/down presses step the
// requested mode, strobe it to the clock manager and wait for it to be
// reflected back, flagging a sticky error if it never is.
module freq_sel_ctrl
    import freq_sel_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_up,
    input  logic                   btn_down,
    freq_sel_ctrl_if.master        bus
);

    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic              up_ev;
    logic              dn_ev;
    fsm_state_t        state;
    logic [MODE_W-1:0] sel;
    logic [TMR_W-1:0]  timer;
    logic              update;
    logic              busy;
    logic              err;
    logic              limit;

    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .press (up_ev)
    );

    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_down (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_down),
        .press (dn_ev)
    );

    // Request sequencer: accept a single press, issue it, then wait for the
    // clock manager to echo the mode or time out; presses while busy are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= MODE_MIN;
            timer  <= '0;
            update <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
            limit  <= 1'b0;
        end else begin
            update <= 1'b0;
            limit  <= 1'b0;
            unique case (state)
                IDLE, ERR: begin
                    if (up_ev && !dn_ev) begin
                        if (sel != MODE_MAX) begin
                            sel    <= sel + MODE_W'(1);
                            state  <= ISSUE;
                            update <= 1'b1;
                            busy   <= 1'b1;
                        end else begin
                            limit <= 1'b1;
                        end
                    end else if (dn_ev && !up_ev) begin
                        if (sel != MODE_MIN) begin
                            sel    <= sel - MODE_W'(1);
                            state  <= ISSUE;
                            update <= 1'b1;
                            busy   <= 1'b1;
                        end else begin
                            limit <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_ACK;
                    timer <= '0;
                end
                WAIT_ACK: begin
                    if (bus.prog_out == sel) begin
                        state <= IDLE;
                        err   <= 1'b0;
                        busy  <= 1'b0;
                    end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                        state <= ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.prog_in = sel;
    assign bus.update  = update;
    assign bus.busy    = busy;
    assign bus.err     = err;
    assign bus.limit   = limit;

endmodule

// File: tb/tb_freq_sel_ctrl.sv
// Bench for freq_sel_ctrl: directed scenarios plus random button/acknowledge
// traffic, checked every cycle against a transaction-level reference model.
module tb_freq_sel_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;

    freq_sel_ctrl_if bus();

    freq_sel_ctrl #(.DEBOUNCE_CNT(DEB), .ACK_TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: sampled button history, debounced levels, and the
    // request tracked as its age in cycles (-1 = no request outstanding)
    int m_s0[2], m_s1[2], m_stab[2], m_stab_d[2], m_run[2];
    int m_sel, m_age, m_err, m_lim;

    // Clock-manager environment: 0 = never acks, 1 = loads on update, 2 = delayed
    int ack_mode = 1;
    int ack_delay = 4;
    int cd = -1;
    int pend = 0;

    // Observed event counters for scenario checks
    int n_upd = 0, n_lim = 0, n_busy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_s0[b] = 0; m_s1[b] = 0; m_stab[b] = 0; m_stab_d[b] = 0; m_run[b] = 0;
        end
        m_sel = 0; m_age = -1; m_err = 0; m_lim = 0;
        cd = -1;
    endtask

    task automatic model_edge(input int raw_up, input int raw_dn, input int po);
        int ev_up, ev_dn, raw[2];
        raw[0] = raw_up; raw[1] = raw_dn;
        ev_up = (m_stab[0] == 1 && m_stab_d[0] == 0);
        ev_dn = (m_stab[1] == 1 && m_stab_d[1] == 0);
        m_lim = 0;
        if (m_age < 0) begin
            if (ev_up && !ev_dn) begin
                if (m_sel < 7) begin m_sel++; m_age = 0; end else m_lim = 1;
            end else if (ev_dn && !ev_up) begin
                if (m_sel > 0) begin m_sel--; m_age = 0; end else m_lim = 1;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (po == m_sel) begin
            m_age = -1; m_err = 0;
        end else if (m_age == TMO) begin
            m_age = -1; m_err = 1;
        end else begin
            m_age++;
        end
        for (int b = 0; b < 2; b++) begin
            m_stab_d[b] = m_stab[b];
            if (m_s1[b] != m_stab[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin m_stab[b] = m_s1[b]; m_run[b] = 0; end
            end else begin
                m_run[b] = 0;
            end
            m_s1[b] = m_s0[b];
            m_s0[b] = raw[b];
        end
    endtask

    task automatic check_outputs();
        chk("prog_in", 32'(bus.prog_in), 32'(m_sel));
        chk("update",  32'(bus.update),  32'(m_age == 0));
        chk("busy",    32'(bus.busy),    32'(m_age >= 0));
        chk("err",     32'(bus.err),     32'(m_err));
        chk("limit",   32'(bus.limit),   32'(m_lim));
    endtask

    task automatic step();
        int upd_pre, pin_pre, po;
        upd_pre = int'(bus.update);
        pin_pre = int'(bus.prog_in);
        po      = int'(bus.prog_out);
        @(posedge clk);
        model_edge(int'(btn_up), int'(btn_down), po);
        #1;
        check_outputs();
        n_upd  += int'(bus.update);
        n_lim  += int'(bus.limit);
        n_busy += int'(bus.busy);
        if (upd_pre == 1) begin
            if (ack_mode == 1) bus.prog_out = 3'(pin_pre);
            else if (ack_mode == 2) begin cd = ack_delay; pend = pin_pre; end
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin bus.prog_out = 3'(pend); cd = -1; end
        end
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_prog_in", 32'(bus.prog_in), 0);
        chk("rst_update",  32'(bus.update),  0);
        chk("rst_busy",    32'(bus.busy),    0);
        chk("rst_err",     32'(bus.err),     0);
        chk("rst_limit",   32'(bus.limit),   0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic press(input logic u, input logic d, input int hold, input int gap);
        btn_up = u; btn_down = d;
        repeat (hold) step();
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (gap) step();
    endtask

    task automatic clear_counts();
        n_upd = 0; n_lim = 0; n_busy = 0;
    endtask

    initial begin
        bus.prog_out = 3'd0;
        model_reset();
        #1;
        do_reset();

        // Single up press with an immediately acknowledging clock manager
        ack_mode = 1; clear_counts();
        press(1'b1, 1'b0, 20, 10);
        chk("s1_updates", 32'(n_upd), 1);
        chk("s1_prog_in", 32'(bus.prog_in), 1);
        chk("s1_busy_cycles", 32'(n_busy), 2);
        chk("s1_err", 32'(bus.err), 0);

        // Bouncing press yields one event
        do_reset(); bus.prog_out = 3'd0; clear_counts();
        for (int i = 0; i < 6; i++) begin
            btn_up = (i % 2 == 0);
            step(); step();
        end
        press(1'b1, 1'b0, 10, 10);
        chk("s2_updates", 32'(n_upd), 1);
        chk("s2_prog_in", 32'(bus.prog_in), 1);

        // Walk up to the top mode, then one press too many
        do_reset(); bus.prog_out = 3'd0; clear_counts();
        for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 6, 8);
        chk("s3_prog_in", 32'(bus.prog_in), 7);
        chk("s3_updates", 32'(n_upd), 7);
        chk("s3_limits", 32'(n_lim), 1);
        do_reset(); bus.prog_out = 3'd0; clear_counts();
        press(1'b0, 1'b1, 6, 8);
        chk("s3_down_limit", 32'(n_lim), 1);
        chk("s3_down_updates", 32'(n_upd), 0);

        // Clock manager never acknowledges, then recovers
        do_reset(); bus.prog_out = 3'd0; ack_mode = 0; clear_counts();
        press(1'b1, 1'b0, 6, 30);
        chk("s4_updates", 32'(n_upd), 1);
        chk("s4_err_set", 32'(bus.err), 1);
        ack_mode = 1;
        press(1'b1, 1'b0, 6, 10);
        chk("s4_err_clear", 32'(bus.err), 0);
        chk("s4_prog_in", 32'(bus.prog_in), 2);

        // Simultaneous presses cancel; a press during WAIT_ACK is dropped
        do_reset(); bus.prog_out = 3'd0; ack_mode = 1; clear_counts();
        press(1'b1, 1'b1, 6, 8);
        chk("s5_both_updates", 32'(n_upd), 0);
        chk("s5_both_limits", 32'(n_lim), 0);
        ack_mode = 2; ack_delay = 12; clear_counts();
        press(1'b1, 1'b0, 6, 6);
        press(1'b1, 1'b0, 6, 20);
        chk("s5_drop_updates", 32'(n_upd), 1);
        chk("s5_drop_prog_in", 32'(bus.prog_in), 1);

        // Reset in the middle of an outstanding request
        do_reset(); bus.prog_out = 3'd0; ack_mode = 1;
        press(1'b1, 1'b0, 6, 8);
        press(1'b1, 1'b0, 6, 8);
        ack_mode = 0;
        press(1'b1, 1'b0, 6, 4);
        chk("s6_prog_in_pre", 32'(bus.prog_in), 3);
        chk("s6_busy_pre", 32'(bus.busy), 1);
        do_reset(); clear_counts();
        repeat (20) step();
        chk("s6_updates_after", 32'(n_upd), 0);
        chk("s6_prog_in_after", 32'(bus.prog_in), 0);

        // Random button and acknowledge traffic
        do_reset(); bus.prog_out = 3'd0;
        for (int s = 0; s < 60; s++) begin
            ack_mode  = int'($urandom_range(0, 2));
            ack_delay = int'($urandom_range(1, 20));
            btn_up    = logic'($urandom_range(0, 1));
            btn_down  = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 12)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
